lsu: RTL
========

# lsu

Load/store unit that initiates all data-memory transfers from the CPU core to the byte-addressed data RAM. It accepts one request at a time from the core over a ready/request handshake. It drives the RAM's enable/size/write/address/data inputs, waits out the RAM's one-cycle registered read latency, and returns a zero- or sign-extended result with a one-cycle done pulse. It also rejects accesses the RAM cannot service.

## Interface
Parameters: none; constants live in `lsu_pkg`.

Clock and reset:
- I_clk  in  1  single clock, all logic on posedge
- I_reset  in  1  synchronous, active-high reset

Core side:
- I_req  in  1  request; sampled only while O_ready=1
- I_write  in  1  1=store, 0=load
- I_size  in  3  3'd1=byte, 3'd2=word; any other value is illegal
- I_signed  in  1  sign-extend byte loads
- I_addr  in  16  byte address
- I_data  in  16  store data; byte store uses [7:0]
- O_ready  out  1  high only in IDLE
- O_done  out  1  one-cycle completion pulse
- O_error  out  1  valid with O_done; request rejected
- O_data  out  16  load result; held until the next load completes

RAM side:
- O_ram_enable  out  1  high only in ACCESS
- O_ram_size  out  3  latched I_size
- O_ram_write  out  1  latched I_write
- O_ram_addr  out  16  latched I_addr, all 16 bits passed through
- O_ram_data  out  16  latched I_data
- I_ram_data  in  16  RAM registered read data

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: O_ready=1. On I_req=1, latch write, size, signed, addr and data, then check legality.
  - Legal request: go to ACCESS.
  - Illegal request: go to DONE with the error flag set. Illegal means I_size not 1 or 2, or I_size=2 with I_addr[11:0]=12'hFFF (the second byte would fall past the end of RAM).
- ACCESS: O_ram_enable=1 for exactly one cycle. The RAM performs the operation on that edge. A store goes to DONE; a load goes to WAIT.
- WAIT: I_ram_data is valid. On the edge leaving WAIT:
  - Word load: O_data <= I_ram_data.
  - Byte load: O_data <= {ext, I_ram_data[7:0]}, where ext is 8 copies of bit 7 or zero (see Configuration).
  - Next state is DONE.
- DONE: O_done=1. O_error=1 only for rejected requests. Next state is IDLE unconditionally.
- I_req outside IDLE is ignored; it is not queued.
- O_ram_* fields hold their last latched values outside ACCESS; only O_ram_enable qualifies them.
- Stores and errors do not modify O_data.
- Address bits [15:12] are not checked.

## Timing
- Reset: state=IDLE; O_ready=1; O_done, O_error, O_ram_enable, O_ram_write = 0; O_data, O_ram_addr, O_ram_data = 0; O_ram_size = 3'd0.
- Reset mid-operation, in any state: IDLE is reached on the same edge. No done pulse is produced and O_ram_enable drops immediately. A store is abandoned if reset coincides with its ACCESS edge; the RAM also ignores that edge.
- Let request accept edge = E0.
  - Store: ACCESS is the cycle after E0; O_done is high in the 2nd cycle after E0.
  - Load: O_done is high in the 3rd cycle after E0, with O_data valid in the same cycle.
  - Error: O_done and O_error are high in the 1st cycle after E0; no RAM enable is issued.
- Throughput: the next accept happens no earlier than the cycle after DONE. Peak rates are one store per 3 cycles and one load per 4 cycles.
- O_done and O_error are never high for more than one consecutive cycle.

## Configuration
- LSU_SIGN_EXT_EN:
  - Defined: a byte load with I_signed=1 replicates bit 7 into O_data[15:8].
  - Undefined: every byte load is zero-extended and I_signed is ignored. The port remains present in both builds.
  - Word loads are unaffected either way.

## Structure
- `lsu_pkg`:
  - state encoding: LSU_IDLE, LSU_ACCESS, LSU_WAIT, LSU_DONE
  - size constants: SIZE_BYTE=3'd1, SIZE_WORD=3'd2
  - RAM bound: RAM_LAST_ADDR=12'hFFF
- One combinational sub-module, `lsu_extend`. Inputs: raw data, size, signed. Output: extended 16-bit result. The LSU_SIGN_EXT_EN conditional is confined to this module.
- FSM, request latches and the legality check stay in `lsu`.

## Test plan
- Word store 16'hBEEF to 16'h0010, then word load from 16'h0010: O_done two cycles after the store accept; load gives O_data=16'hBEEF with O_done three cycles after accept; O_error=0 throughout.
- Byte load from 16'h0010, whose byte value is 8'hEF, with I_signed=1: O_data=16'hFFEF when LSU_SIGN_EXT_EN is defined, 16'h00EF when it is not. With I_signed=0, O_data=16'h00EF in both builds.
- Word store to 16'h0FFF: O_done=O_error=1 one cycle after accept, O_ram_enable stays 0, and a byte load from 16'h0FFF returns the previously stored byte.
- I_size=3'd4 load: O_error=1 and O_data keeps its previous value.
- I_reset pulsed while in WAIT: next cycle O_ready=1, O_done=0, O_ram_enable=0, O_data=0, and no done pulse follows.
- I_req held high with alternating store and load to 16'h0020: one O_done per accept, accepts only while O_ready=1, and no request is dropped or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: state encoding, access sizes and RAM bound shared by the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    localparam logic [2:0]  SIZE_BYTE     = 3'd1;
    localparam logic [2:0]  SIZE_WORD     = 3'd2;
    localparam logic [11:0] RAM_LAST_ADDR = 12'hFFF;

    // A word's second byte must still fall inside the 4 KiB RAM window.
    function automatic logic lsu_legal(input logic [2:0] size, input logic [11:0] addr);
        return size == SIZE_BYTE || (size == SIZE_WORD && addr != RAM_LAST_ADDR);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: widens RAM read data to 16 bits for byte or word loads.
// LSU_SIGN_EXT_EN enables sign extension of signed byte loads; otherwise bytes are zero-extended.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [15:0] raw_i,
    input  logic [2:0]  size_i,
    input  logic        signed_i,
    output logic [15:0] ext_o
);

    logic fill;

`ifdef LSU_SIGN_EXT_EN
    assign fill = signed_i & raw_i[7];
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign fill = 1'b0;
`endif

    assign ext_o = size_i == SIZE_WORD ? raw_i : {{8{fill}}, raw_i[7:0]};

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between the core and the byte-addressed data RAM.
// Build option LSU_SIGN_EXT_EN (handled in lsu_extend) enables sign-extended byte loads.
module lsu
    import lsu_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_req,
    input  logic        I_write,
    input  logic [2:0]  I_size,
    input  logic        I_signed,
    input  logic [15:0] I_addr,
    input  logic [15:0] I_data,
    output logic        O_ready,
    output logic        O_done,
    output logic        O_error,
    output logic [15:0] O_data,
    output logic        O_ram_enable,
    output logic [2:0]  O_ram_size,
    output logic        O_ram_write,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_data,
    input  logic [15:0] I_ram_data
);

    lsu_state_e  state_q;
    logic        ready_q, done_q, error_q, enable_q;
    logic        write_q, signed_q;
    logic [2:0]  size_q;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic [15:0] ext_data;

    lsu_extend u_extend (
        .raw_i    (I_ram_data),
        .size_i   (size_q),
        .signed_i (signed_q),
        .ext_o    (ext_data)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= LSU_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 3'd0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
            rdata_q  <= 16'd0;
        end else begin
            case (state_q)
                LSU_IDLE: if (I_req) begin
                    write_q  <= I_write;
                    size_q   <= I_size;
                    signed_q <= I_signed;
                    addr_q   <= I_addr;
                    wdata_q  <= I_data;
                    ready_q  <= 1'b0;
                    if (lsu_legal(I_size, I_addr[11:0])) begin
                        state_q  <= LSU_ACCESS;
                        enable_q <= 1'b1;
                    end else begin
                        state_q <= LSU_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end
                end
                LSU_ACCESS: begin
                    enable_q <= 1'b0;
                    state_q  <= write_q ? LSU_DONE : LSU_WAIT;
                    done_q   <= write_q;
                end
                LSU_WAIT: begin
                    rdata_q <= ext_data;
                    state_q <= LSU_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

    assign O_ready      = ready_q;
    assign O_done       = done_q;
    assign O_error      = error_q;
    assign O_data       = rdata_q;
    assign O_ram_enable = enable_q;
    assign O_ram_size   = size_q;
    assign O_ram_write  = write_q;
    assign O_ram_addr   = addr_q;
    assign O_ram_data   = wdata_q;

endmodule
